// File: rtl/io_switch_port.sv
// Memory-mapped switch port: sync, debounce, change flags, event counter
// and interrupt, read back through a combinational bus port.
module io_switch_port #(
   parameter int                WIDTH      = 24,
   parameter int                DB_W       = 16,
   parameter logic [DB_W-1:0]   DB_DEFAULT = 16'd1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sel,
   input  logic             we,
   input  logic [1:0]       adr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [WIDTH-1:0] switch,
   output logic [WIDTH-1:0] sw_db,
   output logic             irq
);

   logic [WIDTH-1:0] sync1, sync2, samp;
   logic [WIDTH-1:0] edge_q, edge_nx, db_nx, chg;
   logic [15:0]      cnt_q, cnt_nx;
   logic [DB_W-1:0]  thresh, tcnt, tcnt_nx, thr_m1;
   logic             en, irq_en, tick, inc;
   logic             wr, wr_edge, wr_cnt, wr_ctrl;
   logic             unused_ok;

   assign unused_ok = &{1'b0, wdata};

   assign wr      = sel & we;
   assign wr_edge = wr & (adr == 2'd1);
   assign wr_cnt  = wr & (adr == 2'd2);
   assign wr_ctrl = wr & (adr == 2'd3);

   // thresh=0 is treated as 1: tick every cycle
   always_comb begin
      thr_m1 = (thresh == '0) ? '0 : thresh - 1'b1;
      tick   = en & (tcnt == thr_m1);
      if (wr_ctrl || !en || tick)
         tcnt_nx = '0;
      else
         tcnt_nx = tcnt + 1'b1;
   end

   always_comb begin
      db_nx = sw_db;
      if (tick) begin
         for (int i = 0; i < WIDTH; i++)
            if (sync2[i] == samp[i])
               db_nx[i] = sync2[i];
      end
      chg = db_nx ^ sw_db;
      inc = |chg;
   end

   always_comb begin
      edge_nx = edge_q;
      if (wr_edge)
         edge_nx = edge_q & ~wdata[WIDTH-1:0];
      edge_nx = edge_nx | chg;
   end

   always_comb begin
      cnt_nx = cnt_q;
      if (wr_cnt)
         cnt_nx = {15'd0, inc};
      else if (inc && cnt_q != 16'hFFFF)
         cnt_nx = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '0;
         sync2  <= '0;
         samp   <= '0;
         sw_db  <= '0;
         edge_q <= '0;
         cnt_q  <= '0;
         tcnt   <= '0;
         thresh <= DB_DEFAULT;
         en     <= 1'b1;
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         sync1  <= switch;
         sync2  <= sync1;
         if (tick)
            samp <= sync2;
         sw_db  <= db_nx;
         edge_q <= edge_nx;
         cnt_q  <= cnt_nx;
         tcnt   <= tcnt_nx;
         if (wr_ctrl) begin
            thresh <= wdata[DB_W-1:0];
            en     <= wdata[16];
            irq_en <= wdata[17];
         end
         irq <= irq_en & (|edge_nx);
      end
   end

   always_comb begin
      rdata = '0;
      if (sel) begin
         unique case (adr)
            2'd0: rdata[WIDTH-1:0] = sw_db;
            2'd1: rdata[WIDTH-1:0] = edge_q;
            2'd2: rdata[15:0]      = cnt_q;
            2'd3: begin
               rdata[DB_W-1:0] = thresh;
               rdata[16]       = en;
               rdata[17]       = irq_en;
            end
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_switch_port.sv
// Directed bench for io_switch_port with a queue of expected results.
module tb_io_switch_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel, we;
   logic [1:0]  adr;
   logic [31:0] wdata, rdata;
   logic [23:0] switch, sw_db;
   logic        irq;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];

   io_switch_port dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .we(we), .adr(adr),
      .wdata(wdata), .rdata(rdata), .switch(switch),
      .sw_db(sw_db), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic cmp(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty obs=%h", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic rd(input logic [1:0] a);
      @(negedge clk);
      sel = 1'b1; we = 1'b0; adr = a;
      #1 cmp(rdata);
      sel = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; we = 1'b1; adr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; we = 1'b0; wdata = '0;
   endtask

   task automatic wait_db(input logic [23:0] v, input int lim);
      for (int n = 0; n < lim; n++) begin
         @(negedge clk);
         if (sw_db === v) break;
      end
   endtask

   initial begin
      int n;
      logic [31:0] c, c1;
      rst_n = 1'b0; sel = 0; we = 0; adr = 0; wdata = 0;
      switch = 24'hFFFFFF;
      repeat (3) @(negedge clk);

      // reset values
      expect_val("rst_data", 32'h0);       rd(2'd0);
      expect_val("rst_edge", 32'h0);       rd(2'd1);
      expect_val("rst_cnt", 32'h0);        rd(2'd2);
      expect_val("rst_ctrl", 32'h0001_03E8); rd(2'd3);
      expect_val("rst_irq", 32'h0);        cmp({31'd0, irq});

      switch = 24'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // debounce with thresh=4
      wr(2'd3, 32'h0001_0004);
      @(negedge clk);
      switch = 24'h000005;
      wait_db(24'h000005, 10);
      expect_val("db_swdb", 32'h5);  cmp({8'd0, sw_db});
      expect_val("db_edge", 32'h5);  rd(2'd1);
      expect_val("db_cnt", 32'h1);   rd(2'd2);

      // 3-clock glitch on bit 8
      @(negedge clk); switch = 24'h000105;
      repeat (3) @(negedge clk);
      switch = 24'h000005;
      repeat (20) @(negedge clk);
      expect_val("glitch_data", 32'h5); rd(2'd0);
      expect_val("glitch_cnt", 32'h1);  rd(2'd2);

      // interrupt and W1C
      wr(2'd1, 32'hFFFF_FFFF);
      expect_val("w1c_all", 32'h0); rd(2'd1);
      wr(2'd3, 32'h0003_0001);
      @(negedge clk); switch = 24'h000004;
      n = 0;
      while (irq !== 1'b1 && n < 12) begin
         @(negedge clk); n++;
      end
      expect_val("irq_set", 32'h1);  cmp({31'd0, irq});
      expect_val("irq_edge", 32'h1); rd(2'd1);
      expect_val("irq_cnt", 32'h2);  rd(2'd2);
      expect_val("irq_data", 32'h4); rd(2'd0);
      wr(2'd1, 32'h1);
      expect_val("irq_clr", 32'h0);  cmp({31'd0, irq});
      expect_val("edge_clr", 32'h0); rd(2'd1);
      wr(2'd1, 32'h0);
      expect_val("edge_w0", 32'h0);  rd(2'd1);

      // W1C of bit 2 on the edge sw_db[2] falls
      @(negedge clk); switch = 24'h000000;
      repeat (2) @(negedge clk);
      wr(2'd1, 32'h4);
      expect_val("coll_edge", 32'h4); rd(2'd1);
      expect_val("coll_irq", 32'h1);  cmp({31'd0, irq});
      expect_val("coll_cnt", 32'h3);  rd(2'd2);
      expect_val("coll_data", 32'h0); rd(2'd0);

      // saturation: two bits toggling out of phase, one event per cycle
      wr(2'd3, 32'h0001_0000);
      for (int i = 0; i < 65600; i++) begin
         @(negedge clk);
         c = i; c1 = i + 1;
         switch = {22'd0, c1[1], c[1]};
      end
      expect_val("sat_cnt", 32'hFFFF); rd(2'd2);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         c = i; c1 = i + 1;
         switch = {22'd0, c1[1], c[1]};
      end
      expect_val("sat_hold", 32'hFFFF); rd(2'd2);
      @(negedge clk); switch = 24'h0;
      repeat (10) @(negedge clk);
      expect_val("sat_edge", 32'h7); rd(2'd1);

      // CNT write coincident with a change
      @(negedge clk); switch = 24'h000001;
      repeat (2) @(negedge clk);
      wr(2'd2, 32'h0);
      expect_val("cnt_coll", 32'h1); rd(2'd2);
      repeat (5) @(negedge clk);
      expect_val("cnt_data", 32'h1); rd(2'd0);

      // freeze with en=0, then resume
      wr(2'd3, 32'h0000_0001);
      @(negedge clk); switch = 24'h0000F0;
      repeat (20) @(negedge clk);
      expect_val("frz_data", 32'h1); rd(2'd0);
      expect_val("frz_cnt", 32'h1);  rd(2'd2);
      wr(2'd3, 32'h0001_0000);
      repeat (10) @(negedge clk);
      expect_val("res_swdb", 32'hF0); cmp({8'd0, sw_db});
      expect_val("res_cnt", 32'h2);   rd(2'd2);
      expect_val("res_edge", 32'hF7); rd(2'd1);

      // bus idle: writes with sel=0 are ignored, rdata is 0
      @(negedge clk);
      sel = 0; we = 1; adr = 2'd1; wdata = 32'hFFFF_FFFF;
      #1 expect_val("idle_rdata", 32'h0); cmp(rdata);
      @(negedge clk); adr = 2'd3; wdata = 32'h0;
      @(negedge clk); we = 0; wdata = 0;
      expect_val("idle_edge", 32'hF7);     rd(2'd1);
      expect_val("idle_ctrl", 32'h0001_0000); rd(2'd3);
      expect_val("idle_irq", 32'h0);       cmp({31'd0, irq});

      // DATA is read-only
      wr(2'd0, 32'hFFFF_FFFF);
      expect_val("data_ro", 32'hF0); rd(2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
